// File: rtl/vga_game_pkg.sv
// Shared constants and types for the VGA game display path.
package vga_game_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CMP_W   = COORD_W + 1;
  localparam int unsigned RGB_W   = 12;

  localparam logic [RGB_W-1:0] BLACK    = 12'h000;
  localparam logic [RGB_W-1:0] WHITE    = 12'hFFF;
  localparam logic [RGB_W-1:0] RED      = 12'hF00;
  localparam logic [RGB_W-1:0] GREEN    = 12'h0F0;
  localparam logic [RGB_W-1:0] DARK_RED = 12'h400;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLASH = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/pipe_hit_unit.sv
// Combinational test: is the scan position inside one pipe (outside its gap)?
module pipe_hit_unit
  import vga_game_pkg::*;
#(
  parameter int unsigned PIPE_HW = 50,
  parameter int unsigned GAP_H   = 100
) (
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               en,
  output logic               hit_c
);

  localparam logic [CMP_W-1:0] HW  = CMP_W'(PIPE_HW);
  localparam logic [CMP_W-1:0] GAP = CMP_W'(GAP_H);

  logic [CMP_W-1:0] h, v, x, y;

  // Zero-extended operands; additions only, so the left edge clips instead of wrapping
  always_comb begin
    h     = CMP_W'(hcount);
    v     = CMP_W'(vcount);
    x     = CMP_W'(px);
    y     = CMP_W'(py);
    hit_c = en && (h + HW >= x) && (h <= x + HW) && ((v <= y) || (v >= y + GAP));
  end

endmodule

// File: rtl/vga_scene_renderer.sv
// Per-pixel scene renderer: pipes, bird, background and collision sequence.
module vga_scene_renderer
  import vga_game_pkg::*;
#(
  parameter int unsigned      N_PIPES      = 2,
  parameter int unsigned      PIPE_HW      = 50,
  parameter int unsigned      GAP_H        = 100,
  parameter int unsigned      BIRD_HS      = 10,
  parameter int unsigned      FLASH_FRAMES = 8,
  parameter logic [RGB_W-1:0] BG_COLOR     = RED,
  parameter logic [RGB_W-1:0] PIPE_COLOR   = GREEN,
  parameter logic [RGB_W-1:0] BIRD_COLOR   = WHITE,
  parameter logic [RGB_W-1:0] DEAD_COLOR   = DARK_RED
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bright,
  input  logic [COORD_W-1:0]         hCount,
  input  logic [COORD_W-1:0]         vCount,
  input  logic [COORD_W-1:0]         bird_x,
  input  logic [COORD_W-1:0]         bird_y,
  input  logic [COORD_W*N_PIPES-1:0] pipe_x,
  input  logic [COORD_W*N_PIPES-1:0] pipe_y,
  input  logic [N_PIPES-1:0]         pipe_en,
  input  logic                       clear_hit,
  output logic [RGB_W-1:0]           rgb,
  output logic                       hit,
  output logic                       hit_pulse
);

  localparam int unsigned      CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FLASH_FRAMES);
  localparam logic [CMP_W-1:0] BHS = CMP_W'(BIRD_HS);

  logic                       frame_start_c;
  point_t                     bird_s;
  logic [COORD_W*N_PIPES-1:0] pipe_x_s, pipe_y_s;
  logic [N_PIPES-1:0]         pipe_en_s;
  logic [N_PIPES-1:0]         pipe_hits_c;
  logic                       bird_hit_c;
  logic                       bright_d1, pipe_hit, bird_hit;
  state_t                     state, state_n;
  logic [CNT_W-1:0]           flash_cnt, cnt_n;
  logic                       hit_n, pulse_n, collide_c;
  logic [RGB_W-1:0]           bg_c, rgb_n;

  assign frame_start_c = (hCount == '0) && (vCount == '0);

  // Capture object positions once per frame so the picture cannot tear
  always_ff @(posedge clk) begin
    if (!reset) begin
      bird_s    <= '0;
      pipe_x_s  <= '0;
      pipe_y_s  <= '0;
      pipe_en_s <= '0;
    end else if (frame_start_c) begin
      bird_s    <= '{x: bird_x, y: bird_y};
      pipe_x_s  <= pipe_x;
      pipe_y_s  <= pipe_y;
      pipe_en_s <= pipe_en;
    end
  end

  for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
    pipe_hit_unit #(.PIPE_HW(PIPE_HW), .GAP_H(GAP_H)) u_pipe (
      .hcount (hCount),
      .vcount (vCount),
      .px     (pipe_x_s[COORD_W*i +: COORD_W]),
      .py     (pipe_y_s[COORD_W*i +: COORD_W]),
      .en     (pipe_en_s[i]),
      .hit_c  (pipe_hits_c[i])
    );
  end

  // Bird square test against the latched centre, inclusive on all sides
  always_comb begin
    bird_hit_c = (CMP_W'(hCount) + BHS >= CMP_W'(bird_s.x)) &&
                 (CMP_W'(hCount) <= CMP_W'(bird_s.x) + BHS) &&
                 (CMP_W'(vCount) + BHS >= CMP_W'(bird_s.y)) &&
                 (CMP_W'(vCount) <= CMP_W'(bird_s.y) + BHS);
  end

  // Stage 1: register visibility and geometry hits
  always_ff @(posedge clk) begin
    if (!reset) begin
      bright_d1 <= 1'b0;
      pipe_hit  <= 1'b0;
      bird_hit  <= 1'b0;
    end else begin
      bright_d1 <= bright;
      pipe_hit  <= |pipe_hits_c;
      bird_hit  <= bird_hit_c;
    end
  end

  // Stage 2 / FSM next state: collision sequence, background and colour priority
  always_comb begin
    state_n   = state;
    cnt_n     = flash_cnt;
    hit_n     = hit;
    pulse_n   = 1'b0;
    bg_c      = BG_COLOR;
    rgb_n     = BLACK;
    collide_c = bright_d1 && pipe_hit && bird_hit;
    case (state)
      ST_RUN: begin
        if (collide_c) begin
          state_n = ST_FLASH;
          hit_n   = 1'b1;
          pulse_n = 1'b1;
          cnt_n   = '0;
        end
      end
      ST_FLASH: begin
        bg_c = flash_cnt[0] ? BLACK : BG_COLOR;
        if (frame_start_c) begin
          cnt_n = flash_cnt + CNT_W'(1);
          if (cnt_n == CNT_END) state_n = ST_DEAD;
        end
      end
      ST_DEAD: bg_c = DEAD_COLOR;
      default: state_n = ST_RUN;
    endcase
    // A clear in the same cycle as a collision discards the collision
    if (clear_hit) begin
      state_n = ST_RUN;
      hit_n   = 1'b0;
      pulse_n = 1'b0;
      cnt_n   = '0;
    end
    if (!bright_d1)    rgb_n = BLACK;
    else if (pipe_hit) rgb_n = PIPE_COLOR;
    else if (bird_hit) rgb_n = BIRD_COLOR;
    else               rgb_n = bg_c;
  end

  // State, flash counter, hit flags and pixel output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      flash_cnt <= '0;
      hit       <= 1'b0;
      hit_pulse <= 1'b0;
      rgb       <= '0;
    end else begin
      state     <= state_n;
      flash_cnt <= cnt_n;
      hit       <= hit_n;
      hit_pulse <= pulse_n;
      rgb       <= rgb_n;
    end
  end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Scoreboard bench for vga_scene_renderer: driver pushes expectations, monitor checks them.
module tb_vga_scene_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic [9:0]  bird_x = '0, bird_y = '0;
  logic [19:0] pipe_x = '0, pipe_y = '0;
  logic [1:0]  pipe_en = '0;
  logic        clear_hit = 1'b0;
  logic [11:0] rgb;
  logic        hit, hit_pulse;

  typedef struct {
    logic [11:0] rgb;
    logic        hit;
    logic        pulse;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  exp_t  e;
  string nm;
  int    vectors = 0;
  int    fails = 0;
  logic  tag_in = 1'b0, tag_d1 = 1'b0, tag_d2 = 1'b0;
  logic  direct_req = 1'b0;
  logic  end_chk = 1'b0, end_done = 1'b0;

  localparam logic [11:0] C_BG   = 12'hF00;
  localparam logic [11:0] C_PIPE = 12'h0F0;
  localparam logic [11:0] C_BIRD = 12'hFFF;
  localparam logic [11:0] C_DEAD = 12'h400;
  localparam logic [11:0] C_BLK  = 12'h000;

  vga_scene_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .bright    (bright),
    .hCount    (hCount),
    .vCount    (vCount),
    .bird_x    (bird_x),
    .bird_y    (bird_y),
    .pipe_x    (pipe_x),
    .pipe_y    (pipe_y),
    .pipe_en   (pipe_en),
    .clear_hit (clear_hit),
    .rgb       (rgb),
    .hit       (hit),
    .hit_pulse (hit_pulse)
  );

  always #5 clk = ~clk;

  // Tag follows each checked pixel through the 2-cycle render latency
  always @(posedge clk) begin
    tag_d1 <= tag_in;
    tag_d2 <= tag_d1;
  end

  // Monitor: pop and compare whenever a tagged pixel (or direct check) is presented
  always @(negedge clk) begin
    if (tag_d2 || direct_req) begin
      vectors++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL underflow: output presented with no expected entry");
      end else begin
        e  = sbq.pop_front();
        nm = nameq.pop_front();
        if (rgb !== e.rgb) begin
          fails++;
          $display("FAIL %s rgb got %h want %h", nm, rgb, e.rgb);
        end
        if (hit !== e.hit) begin
          fails++;
          $display("FAIL %s hit got %b want %b", nm, hit, e.hit);
        end
        if (hit_pulse !== e.pulse) begin
          fails++;
          $display("FAIL %s hit_pulse got %b want %b", nm, hit_pulse, e.pulse);
        end
      end
    end
    if (end_chk && !end_done) begin
      end_done <= 1'b1;
      vectors++;
      if (sbq.size() != 0) begin
        fails++;
        $display("FAIL drain: %0d expected entries never checked, want 0", sbq.size());
      end
    end
  end

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic br,
                       input logic clr, input logic chk, input string name,
                       input logic [11:0] er, input logic eh, input logic ep);
    exp_t x;
    @(posedge clk); #1;
    hCount    = h;
    vCount    = v;
    bright    = br;
    clear_hit = clr;
    tag_in    = chk;
    if (chk) begin
      x.rgb = er; x.hit = eh; x.pulse = ep;
      sbq.push_back(x);
      nameq.push_back(name);
    end
  endtask

  task automatic vec(input logic [9:0] h, input logic [9:0] v, input string name,
                     input logic [11:0] er, input logic eh, input logic ep);
    drive(h, v, 1'b1, 1'b0, 1'b1, name, er, eh, ep);
  endtask

  task automatic idle(input logic [9:0] h, input logic [9:0] v);
    drive(h, v, 1'b0, 1'b0, 1'b0, "", '0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    idle(10'd0, 10'd0);
  endtask

  // Check outputs at the next falling edge, outside the pixel pipeline
  task automatic direct(input string name, input logic [11:0] er, input logic eh, input logic ep);
    exp_t x;
    x.rgb = er; x.hit = eh; x.pulse = ep;
    sbq.push_back(x);
    nameq.push_back(name);
    direct_req = 1'b1;
    @(posedge clk); #1;
    direct_req = 1'b0;
  endtask

  initial begin
    bird_x = 10'd400; bird_y = 10'd300;
    hCount = 10'd5; vCount = 10'd700;
    repeat (3) @(posedge clk);
    #1;
    direct("reset_state", C_BLK, 1'b0, 1'b0);
    reset = 1'b1;

    // Shadow cleared by reset: bird not yet latched at (400,300)
    vec(10'd400, 10'd300, "no_latch_before_frame", C_BG, 1'b0, 1'b0);

    // Bird-only frame
    frame();
    vec(10'd400, 10'd300, "bird_centre", C_BIRD, 1'b0, 1'b0);
    vec(10'd390, 10'd290, "bird_corner_tl", C_BIRD, 1'b0, 1'b0);
    vec(10'd410, 10'd310, "bird_corner_br", C_BIRD, 1'b0, 1'b0);
    vec(10'd389, 10'd300, "bird_left_out", C_BG, 1'b0, 1'b0);
    vec(10'd400, 10'd311, "bird_below_out", C_BG, 1'b0, 1'b0);
    drive(10'd400, 10'd300, 1'b0, 1'b0, 1'b1, "not_bright", C_BLK, 1'b0, 1'b0);

    // Mid-frame move is deferred to the next frame
    idle(10'd10, 10'd100);
    bird_x = 10'd500;
    vec(10'd400, 10'd300, "midframe_old_pos", C_BIRD, 1'b0, 1'b0);
    vec(10'd500, 10'd300, "midframe_new_pos", C_BG, 1'b0, 1'b0);

    // Next frame: bird moved, pipe 0 enabled at (300,200), pipe 1 disabled
    pipe_x  = {10'd600, 10'd300};
    pipe_y  = {10'd0, 10'd200};
    pipe_en = 2'b01;
    frame();
    vec(10'd500, 10'd300, "bird_moved", C_BIRD, 1'b0, 1'b0);
    vec(10'd400, 10'd300, "bird_old_gone", C_BG, 1'b0, 1'b0);
    vec(10'd250, 10'd200, "pipe_left_top_edge", C_PIPE, 1'b0, 1'b0);
    vec(10'd350, 10'd300, "pipe_right_gap_bottom", C_PIPE, 1'b0, 1'b0);
    vec(10'd300, 10'd250, "pipe_gap", C_BG, 1'b0, 1'b0);
    vec(10'd300, 10'd299, "pipe_gap_last_row", C_BG, 1'b0, 1'b0);
    vec(10'd249, 10'd100, "pipe_left_out", C_BG, 1'b0, 1'b0);
    vec(10'd351, 10'd100, "pipe_right_out", C_BG, 1'b0, 1'b0);
    vec(10'd600, 10'd500, "pipe1_disabled", C_BG, 1'b0, 1'b0);

    // Collision: bird at (300,195) overlaps pipe 0 above the gap
    bird_x = 10'd300; bird_y = 10'd195;
    frame();
    vec(10'd300, 10'd150, "pipe_no_bird", C_PIPE, 1'b0, 1'b0);
    vec(10'd300, 10'd195, "collide_first", C_PIPE, 1'b1, 1'b1);
    vec(10'd300, 10'd196, "collide_repeat", C_PIPE, 1'b1, 1'b0);
    vec(10'd100, 10'd100, "flash_cnt0", C_BG, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      frame();
      if (k == 8)      vec(10'd100, 10'd100, "dead_bg", C_DEAD, 1'b1, 1'b0);
      else if (k % 2)  vec(10'd100, 10'd100, "flash_black", C_BLK, 1'b1, 1'b0);
      else             vec(10'd100, 10'd100, "flash_red", C_BG, 1'b1, 1'b0);
    end
    vec(10'd300, 10'd203, "dead_bird_drawn", C_BIRD, 1'b1, 1'b0);
    vec(10'd300, 10'd195, "dead_collide_ignored", C_PIPE, 1'b1, 1'b0);

    // Clear coincides with a collision: clear wins, then a new collision re-triggers
    vec(10'd300, 10'd195, "clear_with_collision", C_PIPE, 1'b0, 1'b0);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, "after_clear_run", C_BG, 1'b0, 1'b0);
    vec(10'd300, 10'd195, "retrigger", C_PIPE, 1'b1, 1'b1);
    vec(10'd300, 10'd196, "retrigger_no_pulse", C_PIPE, 1'b1, 1'b0);
    vec(10'd100, 10'd100, "reflash_cnt0", C_BG, 1'b1, 1'b0);

    // Left-edge clipping while flashing (odd frame, black background)
    pipe_x = {10'd600, 10'd20};
    bird_x = 10'd700; bird_y = 10'd400;
    frame();
    vec(10'd0, 10'd100, "clip_h0", C_PIPE, 1'b1, 1'b0);
    vec(10'd70, 10'd100, "clip_h70", C_PIPE, 1'b1, 1'b0);
    vec(10'd71, 10'd100, "clip_h71", C_BLK, 1'b1, 1'b0);
    vec(10'd1000, 10'd100, "no_wrap_h1000", C_BLK, 1'b1, 1'b0);
    vec(10'd1023, 10'd100, "no_wrap_h1023", C_BLK, 1'b1, 1'b0);

    // Reset mid-FLASH with a pipe pixel on the output
    drive(10'd0, 10'd100, 1'b1, 1'b0, 1'b0, "", '0, 1'b0, 1'b0);
    drive(10'd0, 10'd100, 1'b1, 1'b0, 1'b0, "", '0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    direct("reset_mid_flash", C_BLK, 1'b0, 1'b0);

    frame();
    vec(10'd100, 10'd100, "run_after_reset", C_BG, 1'b0, 1'b0);
    vec(10'd0, 10'd100, "pipe_after_reset", C_PIPE, 1'b0, 1'b0);

    repeat (4) idle(10'd5, 10'd700);
    end_chk = 1'b1;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/vga_scene_renderer.md
Name: vga_scene_renderer

Overview:
- Parametrised successor to the single-pipe pixel painter. Renders the background, up to N_PIPES pipes and the bird for each scan position supplied by the VGA timing block.
- Latches object positions once per frame so the picture does not tear. Detects bird/pipe pixel overlap, sets a sticky hit flag, and runs a flash/dead background sequence.
- Sits between the VGA sync generator and the board RGB pins. Drives the game FSM with the hit signal.

Parameters:
- N_PIPES, 2, number of pipe channels (1..8)
- PIPE_HW, 50, pipe half-width in pixels
- GAP_H, 100, vertical gap height below pipe_y
- BIRD_HS, 10, bird half-size in pixels
- FLASH_FRAMES, 8, number of frames the background flashes after a hit
- BG_COLOR, 12'hF00, normal background colour
- PIPE_COLOR, 12'h0F0, pipe colour
- BIRD_COLOR, 12'hFFF, bird colour
- DEAD_COLOR, 12'h400, background colour in the DEAD state

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- bright  in  1  visible-area qualifier from the sync block
- hCount  in  10  horizontal scan position
- vCount  in  10  vertical scan position
- bird_x  in  10  bird centre X
- bird_y  in  10  bird centre Y
- pipe_x  in  10*N_PIPES  packed pipe centre X values; channel i is at bits [10i+9:10i]
- pipe_y  in  10*N_PIPES  packed gap-top Y values
- pipe_en  in  N_PIPES  per-channel enable; a disabled pipe is neither drawn nor collided
- clear_hit  in  1  one-cycle pulse: clears the hit flag and returns the FSM to RUN
- rgb  out  12  registered pixel colour
- hit  out  1  sticky collision flag
- hit_pulse  out  1  one-cycle pulse on the cycle hit rises

Behaviour:
- Reset (reset==0 at a clk edge):
  - rgb=0, hit=0, hit_pulse=0.
  - FSM=RUN, flash counter=0.
  - Shadow registers are cleared: all pipes disabled, bird at (0,0).
- Frame latch:
  - When hCount==0 && vCount==0, the shadow registers capture bird_x, bird_y, pipe_x, pipe_y and pipe_en.
  - Geometry compares only against the shadow values.
  - Input changes mid-frame have no visible effect until the next frame.
- Pipeline: 2-cycle latency from (hCount, vCount, bright) to rgb.
  - S1 registers: bright_d1, pipe_hit (OR over enabled channels), bird_hit.
  - S2 registers rgb.
- Arithmetic: all compares use 11-bit zero-extended operands. No subtraction is used, so nothing wraps.
  - Pipe region: hCount+PIPE_HW >= px, AND hCount <= px+PIPE_HW, AND (vCount <= py OR vCount >= py+GAP_H).
  - Bird region: hCount+BIRD_HS >= bx, AND hCount <= bx+BIRD_HS, AND vCount+BIRD_HS >= by, AND vCount <= by+BIRD_HS.
  - Boundaries are inclusive on all sides.
  - A pipe at px < PIPE_HW clips at the left edge; it does not wrap to the right edge.
- Colour priority at S2:
  - !bright_d1 -> 0.
  - Otherwise pipe -> PIPE_COLOR.
  - Otherwise bird -> BIRD_COLOR.
  - Otherwise the background colour for the current FSM state.
- Collision: a collision event is bright_d1 && pipe_hit && bird_hit.
- FSM:
  - RUN: background is BG_COLOR. A collision event -> FLASH; hit=1 and hit_pulse=1 on the following cycle; flash counter=0.
  - FLASH: at each frame start the flash counter increments. Background is BG_COLOR when counter[0]==0, else 0 (black). When the counter reaches FLASH_FRAMES -> DEAD. Further collisions are ignored.
  - DEAD: background is DEAD_COLOR. Pipes and bird are still drawn. Collisions are ignored.
  - clear_hit in any state: next state RUN, hit=0, counter=0.
    - clear_hit and a collision in the same cycle: clear wins and the collision is discarded.
    - A collision on the next cycle re-triggers the sequence.
- hit_pulse fires only on the RUN->FLASH transition. It never fires on a repeat collision.
- Reset in FLASH or DEAD returns to RUN with hit=0 on the next edge.

Decomposition:
- Shared package vga_game_pkg holds:
  - colour constants (BLACK, WHITE, RED, GREEN, DARK_RED)
  - the FSM state encoding ST_RUN=2'd0, ST_FLASH=2'd1, ST_DEAD=2'd2
  - the 10-bit coordinate width constant
- One sub-module, pipe_hit_unit: the combinational per-channel rectangle/gap test.
  - Parametrised by PIPE_HW and GAP_H.
  - Instantiated N_PIPES times in a generate loop; the outputs are OR-reduced into S1.

Test Plan:
- Reset, then a full frame with all pipes disabled and the bird at (400,300) -> rgb=BIRD_COLOR exactly for h in 390..410 and v in 290..310 (2-cycle delay); BG_COLOR elsewhere in the visible area; 0 when !bright.
- pipe_en=2'b01, px=300, py=200 -> PIPE_COLOR for h 250..350 when v<=200 or v>=300; BG_COLOR at (300,250). Pipe over bird pixels shows PIPE_COLOR.
- Change bird_x from 400 to 500 at v=100 mid-frame -> the current frame still draws at 400; the next frame draws at 500.
- Bird at (300,195) and pipe 0 at (300,200) -> hit rises, with a single-cycle hit_pulse, on the first overlapping pixel plus 2 cycles. Background alternates red/black for 8 frames, then DEAD_COLOR. hit stays 1 throughout.
- In DEAD, assert clear_hit together with a collision event -> state RUN, hit=0, no hit_pulse that cycle. The collision on the next overlapping pixel sets hit again.
- pipe_x=20 with PIPE_HW=50 -> pipe drawn for h 0..70 only; nothing appears near h=1000+. Drop reset low mid-FLASH -> rgb=0 and hit=0 after one edge.
